// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL reset/lock sequencer: holds PLL reset, qualifies lock, bounded retries, FAIL park.
module pll_reset_seq #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic       lost_lock,
    output logic [3:0] retries,
    output logic [2:0] state
);
    localparam int CNT_MAX_A = (RST_HOLD > LOCK_STABLE) ? RST_HOLD : LOCK_STABLE;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int CW        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic            lock_meta;
    logic            lock_s;
    logic [3:0]      retries_nxt;
    logic [3:0]      retries_inc;
    logic            lost_nxt;

    assign state       = cur;
    assign retries_inc = (retries == 4'd15) ? 4'd15 : retries + 4'd1;

    always_comb begin
        nxt         = cur;
        retries_nxt = retries;
        lost_nxt    = 1'b0;
        case (cur)
            S_RESET: begin
                if (cnt == CW'(RST_HOLD - 1))
                    nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock_s) begin
                    nxt = S_STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retries_nxt = retries_inc;
                    nxt         = (retries_inc == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    nxt = S_RESET;
                end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                    nxt         = S_RUN;
                    retries_nxt = 4'd0;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    nxt      = S_RESET;
                    lost_nxt = 1'b1;
                end
            end
            S_FAIL: begin
                if (retry_req) begin
                    nxt         = S_RESET;
                    retries_nxt = 4'd0;
                end
            end
            default: nxt = S_RESET;
        endcase
    end

    // Outputs are registered from the next state so they move on the same edge as state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cur       <= S_RESET;
            cnt       <= '0;
            retries   <= 4'd0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
            cur       <= nxt;
            cnt       <= (nxt != cur) ? '0 : cnt + CW'(1);
            retries   <= retries_nxt;
            pll_rst   <= (nxt == S_RESET) || (nxt == S_FAIL);
            core_rst  <= (nxt != S_RUN);
            ready     <= (nxt == S_RUN);
            fail      <= (nxt == S_FAIL);
            lost_lock <= lost_nxt;
        end
    end
endmodule
